// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : Circular in-order retirement queue for a Tomasulo core.
//             Allocates one entry per issued instruction, collects CDB
//             results, commits one entry per cycle in program order and
//             flushes everything when a mispredicted branch retires.
//  Option   : REORDER_BUFFER_CDB_BYPASS_EN - a CDB write to the waiting
//             head entry commits on the same edge as the write.
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  // decoder allocation
  input  logic             dec_issue_in,
  input  logic [4:0]       dec_rd_in,
  input  logic             dec_has_rd_in,
  input  logic             dec_is_store_in,
  output logic [TAG_W-1:0] rob_next_tag_out,
  output logic             rob_full_out,
  // common data bus
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_data_in,
  input  logic             cdb_mispredict_in,
  input  logic [31:0]      cdb_target_pc_in,
  // commit / recovery
  output logic             rob_commit_signal_out,
  output logic [TAG_W-1:0] rob_commit_tag_out,
  output logic [31:0]      rob_commit_data_out,
  output logic [4:0]       rob_commit_target_out,
  output logic             rob_store_commit_out,
  output logic [TAG_W-1:0] rob_store_tag_out,
  output logic             rob_rollback_out,
  output logic [31:0]      rob_rollback_pc_out
);

  // Tag 0 is reserved as NULL, so one slot of the tag space is unusable.
  localparam int               DEPTH    = (1 << TAG_W) - 1;
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(DEPTH - 1);
  localparam logic [TAG_W-1:0] FULL_CNT = TAG_W'(DEPTH);

  // Control state (reset)
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;

  // Payload state (qualified by busy/ready, no reset needed)
  logic [DEPTH-1:0] has_rd_q, has_rd_d;
  logic [DEPTH-1:0] is_store_q, is_store_d;
  logic [DEPTH-1:0] mispredict_q, mispredict_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      target_pc_q [DEPTH];
  logic [31:0]      target_pc_d [DEPTH];

  // Registered outputs
  logic             commit_signal_q, commit_signal_d;
  logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
  logic [31:0]      commit_data_q, commit_data_d;
  logic [4:0]       commit_target_q, commit_target_d;
  logic             store_commit_q, store_commit_d;
  logic [TAG_W-1:0] store_tag_q, store_tag_d;
  logic             rollback_q, rollback_d;
  logic [31:0]      rollback_pc_q, rollback_pc_d;

  // Decode helpers
  logic [TAG_W-1:0] cdb_idx;
  logic             cdb_hit;
  logic             issue_ok;
  logic             head_ready;
  logic             bypass_hit;
  logic             commit_en;
  logic [31:0]      c_data;
  logic             c_mispredict;
  logic [31:0]      c_target_pc;

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + TAG_W'(1);
  endfunction

  assign rob_full_out          = (count_q == FULL_CNT);
  assign rob_next_tag_out      = tail_q + TAG_W'(1);
  assign rob_commit_signal_out = commit_signal_q;
  assign rob_commit_tag_out    = commit_tag_q;
  assign rob_commit_data_out   = commit_data_q;
  assign rob_commit_target_out = commit_target_q;
  assign rob_store_commit_out  = store_commit_q;
  assign rob_store_tag_out     = store_tag_q;
  assign rob_rollback_out      = rollback_q;
  assign rob_rollback_pc_out   = rollback_pc_q;

  // Qualify CDB / issue requests and select the head's commit source
  always_comb begin
    cdb_idx    = cdb_tag_in - TAG_W'(1);
    // While the rollback pulse is out the rest of the core is flushing.
    cdb_hit    = cdb_valid_in && (cdb_tag_in != '0) && busy_q[cdb_idx] && !rollback_q;
    // Full is judged on the registered count, so a slot freed this cycle
    // cannot be refilled in the same cycle.
    issue_ok   = dec_issue_in && !rob_full_out && !rollback_q;
    head_ready = busy_q[head_q] && ready_q[head_q];
`ifdef REORDER_BUFFER_CDB_BYPASS_EN
    bypass_hit = cdb_hit && (cdb_idx == head_q) && !ready_q[head_q];
`else
    bypass_hit = 1'b0;
`endif
    commit_en    = head_ready || bypass_hit;
    c_data       = bypass_hit ? cdb_data_in       : data_q[head_q];
    c_mispredict = bypass_hit ? cdb_mispredict_in : mispredict_q[head_q];
    c_target_pc  = bypass_hit ? cdb_target_pc_in  : target_pc_q[head_q];
  end

  // Next-state: CDB writeback, in-order commit, allocation, flush
  always_comb begin
    busy_d       = busy_q;
    ready_d      = ready_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    has_rd_d     = has_rd_q;
    is_store_d   = is_store_q;
    mispredict_d = mispredict_q;
    rd_d         = rd_q;
    data_d       = data_q;
    target_pc_d  = target_pc_q;

    commit_signal_d = 1'b0;
    commit_tag_d    = '0;
    commit_data_d   = '0;
    commit_target_d = '0;
    store_commit_d  = 1'b0;
    store_tag_d     = '0;
    rollback_d      = 1'b0;
    rollback_pc_d   = '0;

    if (cdb_hit) begin
      ready_d[cdb_idx]      = 1'b1;
      data_d[cdb_idx]       = cdb_data_in;
      mispredict_d[cdb_idx] = cdb_mispredict_in;
      target_pc_d[cdb_idx]  = cdb_target_pc_in;
    end

    if (commit_en) begin
      // Writes to x0 retire silently, like instructions with no rd.
      if (has_rd_q[head_q] && (rd_q[head_q] != 5'd0)) begin
        commit_signal_d = 1'b1;
        commit_tag_d    = head_q + TAG_W'(1);
        commit_data_d   = c_data;
        commit_target_d = rd_q[head_q];
      end
      if (is_store_q[head_q]) begin
        store_commit_d = 1'b1;
        store_tag_d    = head_q + TAG_W'(1);
      end
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
      count_d         = count_d - TAG_W'(1);
    end

    // The tail slot is never busy when issue is allowed, so it cannot
    // collide with the CDB or commit updates above.
    if (issue_ok) begin
      busy_d[tail_q]     = 1'b1;
      ready_d[tail_q]    = 1'b0;
      has_rd_d[tail_q]   = dec_has_rd_in;
      is_store_d[tail_q] = dec_is_store_in;
      rd_d[tail_q]       = dec_rd_in;
      tail_d             = ptr_inc(tail_q);
      count_d            = count_d + TAG_W'(1);
    end

    // A retiring mispredict discards every younger instruction, including
    // anything issued in this same cycle.
    if (commit_en && c_mispredict) begin
      rollback_d    = 1'b1;
      rollback_pc_d = c_target_pc;
      busy_d        = '0;
      ready_d       = '0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q          <= '0;
      ready_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_signal_q <= 1'b0;
      commit_tag_q    <= '0;
      commit_data_q   <= '0;
      commit_target_q <= '0;
      store_commit_q  <= 1'b0;
      store_tag_q     <= '0;
      rollback_q      <= 1'b0;
      rollback_pc_q   <= '0;
    end else begin
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_signal_q <= commit_signal_d;
      commit_tag_q    <= commit_tag_d;
      commit_data_q   <= commit_data_d;
      commit_target_q <= commit_target_d;
      store_commit_q  <= store_commit_d;
      store_tag_q     <= store_tag_d;
      rollback_q      <= rollback_d;
      rollback_pc_q   <= rollback_pc_d;
    end
  end

  // Entry payload storage
  always_ff @(posedge clk) begin
    has_rd_q     <= has_rd_d;
    is_store_q   <= is_store_d;
    mispredict_q <= mispredict_d;
    rd_q         <= rd_d;
    data_q       <= data_d;
    target_pc_q  <= target_pc_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer
//  Purpose  : Directed self-checking bench for reorder_buffer. Expected
//             output pulses are queued with the cycle they must appear in;
//             every cycle the registered outputs are compared against the
//             queue head or against all-zero.
//  Option   : REORDER_BUFFER_CDB_BYPASS_EN shortens expected commit latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  localparam int TAG_W = 4;
`ifdef REORDER_BUFFER_CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             dec_issue_in = 1'b0;
  logic [4:0]       dec_rd_in = '0;
  logic             dec_has_rd_in = 1'b0;
  logic             dec_is_store_in = 1'b0;
  logic [TAG_W-1:0] rob_next_tag_out;
  logic             rob_full_out;
  logic             cdb_valid_in = 1'b0;
  logic [TAG_W-1:0] cdb_tag_in = '0;
  logic [31:0]      cdb_data_in = '0;
  logic             cdb_mispredict_in = 1'b0;
  logic [31:0]      cdb_target_pc_in = '0;
  logic             rob_commit_signal_out;
  logic [TAG_W-1:0] rob_commit_tag_out;
  logic [31:0]      rob_commit_data_out;
  logic [4:0]       rob_commit_target_out;
  logic             rob_store_commit_out;
  logic [TAG_W-1:0] rob_store_tag_out;
  logic             rob_rollback_out;
  logic [31:0]      rob_rollback_pc_out;

  reorder_buffer #(.TAG_W(TAG_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dec_issue_in          (dec_issue_in),
    .dec_rd_in             (dec_rd_in),
    .dec_has_rd_in         (dec_has_rd_in),
    .dec_is_store_in       (dec_is_store_in),
    .rob_next_tag_out      (rob_next_tag_out),
    .rob_full_out          (rob_full_out),
    .cdb_valid_in          (cdb_valid_in),
    .cdb_tag_in            (cdb_tag_in),
    .cdb_data_in           (cdb_data_in),
    .cdb_mispredict_in     (cdb_mispredict_in),
    .cdb_target_pc_in      (cdb_target_pc_in),
    .rob_commit_signal_out (rob_commit_signal_out),
    .rob_commit_tag_out    (rob_commit_tag_out),
    .rob_commit_data_out   (rob_commit_data_out),
    .rob_commit_target_out (rob_commit_target_out),
    .rob_store_commit_out  (rob_store_commit_out),
    .rob_store_tag_out     (rob_store_tag_out),
    .rob_rollback_out      (rob_rollback_out),
    .rob_rollback_pc_out   (rob_rollback_pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [79:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Packs one cycle's worth of output pulses in a fixed field order.
  function automatic logic [79:0] ev(input logic sig, input logic [3:0] tag,
                                     input logic [31:0] data, input logic [4:0] tgt,
                                     input logic st, input logic [3:0] stag,
                                     input logic rb, input logic [31:0] pc);
    return {sig, tag, data, tgt, st, stag, rb, pc};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int due, input logic [79:0] v);
    exp_t e;
    e.due = due;
    e.v   = v;
    sb.push_back(e);
  endtask

  // One clock, then compare outputs against the scoreboard or idle zero.
  task automatic tick();
    logic [79:0] obs;
    exp_t        e;
    @(posedge clk);
    #1;
    cyc++;
    obs = ev(rob_commit_signal_out, rob_commit_tag_out, rob_commit_data_out,
             rob_commit_target_out, rob_store_commit_out, rob_store_tag_out,
             rob_rollback_out, rob_rollback_pc_out);
    if (!rst && sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("pulse", obs, e.v);
    end else begin
      chk("idle", obs, 80'd0);
    end
  endtask

  task automatic issue(input logic has_rd, input logic [4:0] rd, input logic st);
    dec_issue_in    = 1'b1;
    dec_has_rd_in   = has_rd;
    dec_rd_in       = rd;
    dec_is_store_in = st;
    tick();
    dec_issue_in    = 1'b0;
    dec_has_rd_in   = 1'b0;
    dec_rd_in       = '0;
    dec_is_store_in = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data,
                     input logic mis, input logic [31:0] pc);
    cdb_valid_in      = 1'b1;
    cdb_tag_in        = tag;
    cdb_data_in       = data;
    cdb_mispredict_in = mis;
    cdb_target_pc_in  = pc;
    tick();
    cdb_valid_in      = 1'b0;
    cdb_tag_in        = '0;
    cdb_data_in       = '0;
    cdb_mispredict_in = 1'b0;
    cdb_target_pc_in  = '0;
  endtask

  task automatic drain_and_reset();
    repeat (4) tick();
    chk("sb_empty", 80'(sb.size()), 80'd0);
    sb.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int c;

    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("reset_next_tag", 80'(rob_next_tag_out), 80'd1);
    chk("reset_full", 80'(rob_full_out), 80'd0);

    // Single ALU op: rd=5, data 0x1234
    issue(1'b1, 5'd5, 1'b0);
    chk("issue_next_tag", 80'(rob_next_tag_out), 80'd2);
    push(cyc + LAT, ev(1'b1, 4'd1, 32'h1234, 5'd5, 1'b0, 4'd0, 1'b0, 32'd0));
    cdb(4'd1, 32'h1234, 1'b0, 32'd0);
    drain_and_reset();

    // Out-of-order completion, in-order commit
    issue(1'b1, 5'd1, 1'b0);
    issue(1'b1, 5'd2, 1'b0);
    issue(1'b1, 5'd3, 1'b0);
    cdb(4'd3, 32'h33, 1'b0, 32'd0);
    cdb(4'd2, 32'h22, 1'b0, 32'd0);
    c = cyc;
    push(c + LAT,     ev(1'b1, 4'd1, 32'h11, 5'd1, 1'b0, 4'd0, 1'b0, 32'd0));
    push(c + LAT + 1, ev(1'b1, 4'd2, 32'h22, 5'd2, 1'b0, 4'd0, 1'b0, 32'd0));
    push(c + LAT + 2, ev(1'b1, 4'd3, 32'h33, 5'd3, 1'b0, 4'd0, 1'b0, 32'd0));
    cdb(4'd1, 32'h11, 1'b0, 32'd0);
    drain_and_reset();

    // Fill to 15, ignored 16th issue, retire all, tag wrap
    for (int i = 1; i <= 15; i++) issue(1'b1, 5'(i), 1'b0);
    chk("full_flag", 80'(rob_full_out), 80'd1);
    chk("full_next_tag", 80'(rob_next_tag_out), 80'd1);
    issue(1'b1, 5'd31, 1'b0);
    chk("full_ignore_flag", 80'(rob_full_out), 80'd1);
    chk("full_ignore_tag", 80'(rob_next_tag_out), 80'd1);
    for (int i = 1; i <= 15; i++) begin
      push(cyc + LAT, ev(1'b1, 4'(i), 32'(i * 16), 5'(i), 1'b0, 4'd0, 1'b0, 32'd0));
      cdb(4'(i), 32'(i * 16), 1'b0, 32'd0);
    end
    repeat (LAT) tick();
    chk("retired_full", 80'(rob_full_out), 80'd0);
    issue(1'b1, 5'd6, 1'b0);
    chk("wrap_next_tag", 80'(rob_next_tag_out), 80'd2);
    push(cyc + LAT, ev(1'b1, 4'd1, 32'hCAFE, 5'd6, 1'b0, 4'd0, 1'b0, 32'd0));
    cdb(4'd1, 32'hCAFE, 1'b0, 32'd0);
    drain_and_reset();

    // Mispredicted branch flushes younger ops
    issue(1'b0, 5'd0, 1'b0);
    issue(1'b1, 5'd7, 1'b0);
    issue(1'b1, 5'd8, 1'b0);
    push(cyc + LAT, ev(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b1, 32'h100));
    cdb(4'd1, 32'hDEAD, 1'b1, 32'h100);
    repeat (LAT - 1) tick();
    chk("rb_next_tag", 80'(rob_next_tag_out), 80'd1);
    chk("rb_full", 80'(rob_full_out), 80'd0);
    // Issue and CDB presented during the rollback cycle must be dropped.
    dec_issue_in  = 1'b1;
    dec_has_rd_in = 1'b1;
    dec_rd_in     = 5'd9;
    cdb(4'd2, 32'h77, 1'b0, 32'd0);
    dec_issue_in  = 1'b0;
    dec_has_rd_in = 1'b0;
    dec_rd_in     = '0;
    chk("rb_issue_ignored", 80'(rob_next_tag_out), 80'd1);
    cdb(4'd3, 32'h88, 1'b0, 32'd0);
    repeat (3) tick();
    issue(1'b1, 5'd4, 1'b0);
    chk("post_rb_tag", 80'(rob_next_tag_out), 80'd2);
    push(cyc + LAT, ev(1'b1, 4'd1, 32'h4444, 5'd4, 1'b0, 4'd0, 1'b0, 32'd0));
    cdb(4'd1, 32'h4444, 1'b0, 32'd0);
    drain_and_reset();

    // Store retirement
    issue(1'b0, 5'd0, 1'b1);
    push(cyc + LAT, ev(1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 4'd1, 1'b0, 32'd0));
    cdb(4'd1, 32'hABC, 1'b0, 32'd0);
    drain_and_reset();

    // NULL-tag CDB ignored; x0 write retires silently
    issue(1'b1, 5'd0, 1'b0);
    issue(1'b1, 5'd9, 1'b0);
    cdb(4'd0, 32'h5555, 1'b0, 32'd0);
    repeat (3) tick();
    cdb(4'd1, 32'h1111, 1'b0, 32'd0);
    push(cyc + LAT, ev(1'b1, 4'd2, 32'h99, 5'd9, 1'b0, 4'd0, 1'b0, 32'd0));
    cdb(4'd2, 32'h99, 1'b0, 32'd0);
    drain_and_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
